// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle fetch/decode/execute controller for the 8-bit
//               accumulator machine. Owns PC, ACC and IR, drives the external
//               ALU and talks to 1-cycle synchronous instruction/data memories.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter logic       AUTO_START = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [4:0] dmem_addr,
  input  logic [7:0] dmem_rdata,
  output logic [7:0] dmem_wdata,
  output logic       dmem_we,
  output logic [7:0] alu_acc,
  output logic [7:0] alu_b,
  output logic [1:0] alu_ctrl,
  output logic [7:0] alu_pc,
  input  logic [7:0] alu_result,
  output logic [7:0] acc_out,
  output logic [7:0] pc_out,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEMRD  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [2:0] c_OP_ADD   = 3'b000;
  localparam logic [2:0] c_OP_NAND  = 3'b001;
  localparam logic [2:0] c_OP_BZ    = 3'b010;
  localparam logic [2:0] c_OP_SLT   = 3'b011;
  localparam logic [2:0] c_OP_LOAD  = 3'b100;
  localparam logic [2:0] c_OP_STORE = 3'b101;
  localparam logic [2:0] c_OP_LDI   = 3'b110;
  localparam logic [2:0] c_OP_HALT  = 3'b111;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_acc, w_acc_nxt;
  logic [7:0] r_ir, w_ir_nxt;
  logic [2:0] w_op;
  logic [2:0] w_dec_op;
  logic [7:0] w_arg;

  assign w_op     = r_ir[7:5];
  assign w_dec_op = imem_data[7:5];
  assign w_arg    = {3'b000, r_ir[4:0]};

  // Architectural registers and FSM state; reset wins over any in-flight instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_acc   <= 8'h00;
      r_ir    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_acc   <= w_acc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  // Next-state, register updates and memory/ALU strobes for the current state
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_ir_nxt    = r_ir;
    dmem_addr   = r_ir[4:0];
    dmem_we     = 1'b0;
    alu_b       = 8'h00;
    alu_ctrl    = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (start || AUTO_START) begin
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        w_state_nxt = S_DECODE;
      end

      S_DECODE: begin
        // Issue the data read straight from the fetched word so it lands by EXEC
        w_ir_nxt  = imem_data;
        dmem_addr = imem_data[4:0];
        case (w_dec_op)
          c_OP_ADD, c_OP_NAND, c_OP_SLT, c_OP_LOAD: w_state_nxt = S_MEMRD;
          c_OP_HALT:                                w_state_nxt = S_HALTED;
          default:                                  w_state_nxt = S_EXEC;
        endcase
      end

      S_MEMRD: begin
        w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = r_pc + 8'd1;
        case (w_op)
          c_OP_ADD, c_OP_NAND, c_OP_SLT: begin
            alu_b     = dmem_rdata;
            alu_ctrl  = w_op[1:0];
            w_acc_nxt = alu_result;
          end
          c_OP_BZ: begin
            // The ALU resolves the branch target (PC+1 or arg)
            alu_b    = w_arg;
            alu_ctrl = w_op[1:0];
            w_pc_nxt = alu_result;
          end
          c_OP_LOAD:  w_acc_nxt = dmem_rdata;
          c_OP_STORE: dmem_we   = 1'b1;
          c_OP_LDI:   w_acc_nxt = w_arg;
          default:    w_acc_nxt = r_acc;
        endcase
      end

      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_addr  = r_pc;
  assign dmem_wdata = r_acc;
  assign alu_acc    = r_acc;
  assign alu_pc     = r_pc;
  assign acc_out    = r_acc;
  assign pc_out     = r_pc;
  assign busy       = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign halted     = (r_state == S_HALTED);

endmodule
`default_nettype wire
